decimal_to_bin: RTL and testbench

Sequential BCD-to-binary converter for the scoreboard datapath: accepts a two-digit decimal score (tens, ones) and returns its 7-bit binary value. It is the inverse of the existing binary-to-decimal path. It is used when scores are entered or adjusted digit-wise, for example from buttons or a 7-segment editor, and must be written back into the binary score registers. Conversion is iterative (repeated add of 10) with a start/busy/done handshake.

---
 rtl/decimal_to_bin_pkg.sv | 16 +
 rtl/bcd_digit_valid.sv | 12 +
 rtl/decimal_to_bin.sv | 105 ++++++++++
 tb/tb_decimal_to_bin.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/decimal_to_bin_pkg.sv
// Shared scoreboard constants for the BCD <-> binary score paths.
// bin_to_decimal and the digit editors use the same widths and limits.
package decimal_to_bin_pkg;

  localparam int BIN_W = 7;
  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] BCD_MAX     = 4'd9;
  localparam logic [BIN_W-1:0] TENS_WEIGHT = 7'd10;

  typedef enum logic {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_t;

endpackage : decimal_to_bin_pkg

// File: rtl/bcd_digit_valid.sv
// Combinational check that a 4-bit code is a legal BCD digit (0..9).
// Shared by the converter and the display/editing blocks.
module bcd_digit_valid
  import decimal_to_bin_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic             valid_o
);

  assign valid_o = (digit_i <= BCD_MAX);

endmodule : bcd_digit_valid

// File: rtl/decimal_to_bin.sv
// Iterative two-digit BCD to 7-bit binary converter.
// Loads the ones digit, then adds TENS_WEIGHT once per tens count.
module decimal_to_bin
  import decimal_to_bin_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [BCD_W-1:0] tens_i,
  input  logic [BCD_W-1:0] ones_i,
  output logic [BIN_W-1:0] bin_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  // Handshake: start_i is accepted only in IDLE (busy_o low); done_o pulses
  // for one cycle per accepted request, and start_i during busy is dropped.

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   acc_q, acc_d;
  logic [BCD_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               tens_ok;
  logic               ones_ok;

  bcd_digit_valid u_tens_valid (
    .digit_i (tens_i),
    .valid_o (tens_ok)
  );

  bcd_digit_valid u_ones_valid (
    .digit_i (ones_i),
    .valid_o (ones_ok)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (tens_ok && ones_ok) begin
            acc_d   = {{(BIN_W-BCD_W){1'b0}}, ones_i};
            cnt_d   = tens_i;
            err_d   = 1'b0;
            state_d = ADD;
          end else begin
            // Rejected request still completes so the requester is not left waiting.
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      ADD: begin
        if (cnt_q != '0) begin
          acc_d = acc_q + TENS_WEIGHT;
          cnt_d = cnt_q - 4'd1;
        end else begin
          bin_d   = acc_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ADD);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bin_o  = bin_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule : decimal_to_bin

// File: tb/tb_decimal_to_bin.sv
// Directed self-checking bench for decimal_to_bin: reset, full valid sweep,
// invalid digits, busy-ignore, back-to-back starts and mid-conversion reset.
module tb_decimal_to_bin;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [6:0] bin;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  decimal_to_bin dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .tens_i  (tens),
    .ones_i  (ones),
    .bin_o   (bin),
    .busy_o  (busy),
    .done_o  (done),
    .err_o   (err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver: one valid conversion, measuring latency in edges after the accepting edge.
  task automatic do_conv(input int t, input int o, input string tag);
    int n;
    tens  = 4'(t);
    ones  = 4'(o);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"},  n,          t + 1);
    chk({tag, "_bin"},  32'(bin),   10 * t + o);
    chk({tag, "_err"},  32'(err),   32'd0);
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic do_invalid(input int t, input int o, input int keep, input string tag);
    tens  = 4'(t);
    ones  = 4'(o);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_err"},  32'(err),  32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_bin"},  32'(bin),  keep);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int pulses;

    rst   = 1'b1;
    start = 1'b0;
    tens  = '0;
    ones  = '0;

    // Reset held two cycles; outputs must be zero throughout.
    tick();
    chk("rst_bin",  32'(bin),  32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err",  32'(err),  32'd0);
    rst = 1'b0;
    tick();

    do_conv(4, 2, "first_42");

    // Invalid digits keep the previous result.
    do_invalid(10, 3, 42, "inv_10_3");
    do_invalid(0, 12, 42, "inv_0_12");
    do_conv(7, 3, "after_inv_73");

    // Full valid sweep.
    for (int t = 0; t <= 9; t++) begin
      for (int o = 0; o <= 9; o++) begin
        do_conv(t, o, $sformatf("sweep_%0d_%0d", t, o));
      end
    end

    // Start pulse during busy is ignored.
    tens  = 4'd9;
    ones  = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tens  = 4'd1;
    ones  = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 3;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk("busy_ign_lat", n, 10);
    chk("busy_ign_bin", 32'(bin), 32'd99);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("busy_ign_no_second_done", pulses, 0);
    chk("busy_ign_bin_hold", 32'(bin), 32'd99);

    // Back-to-back: start held high, digits changed when done appears.
    tens  = 4'd7;
    ones  = 4'd3;
    start = 1'b1;
    tick();
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk("b2b_first_lat", n, 8);
    chk("b2b_first_bin", 32'(bin), 32'd73);
    tens = 4'd0;
    ones = 4'd5;
    tick();
    start = 1'b0;
    chk("b2b_gap_done", 32'(done), 32'd0);
    chk("b2b_gap_busy", 32'(busy), 32'd1);
    tick();
    chk("b2b_second_done", 32'(done), 32'd1);
    chk("b2b_second_bin",  32'(bin),  32'd5);
    tick();

    // Reset during a conversion aborts it.
    tens  = 4'd8;
    ones  = 4'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_bin",  32'(bin),  32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err",  32'(err),  32'd0);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("mid_rst_no_done", pulses, 0);
    chk("mid_rst_bin_hold", 32'(bin), 32'd0);
    do_conv(1, 5, "after_rst_15");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_decimal_to_bin
